// File: rtl/alu_128_req_arbiter.sv
// -----------------------------------------------------------------------------
// alu_128_req_arbiter
//
// Purpose:
//   Shares one combinational alu_128bit among NREQ requesters.
//   A round-robin arbiter accepts one {op1, op2, opsel, mode} request and
//   registers it onto the ALU inputs. The next cycle captures the ALU result
//   and flags. The block then presents them, tagged with the requester id, on
//   a single valid/ready response port. It serves one operation at a time:
//   IDLE (grant) -> EXEC (capture) -> RESP (handshake) -> IDLE.
//
// Parameters:
//   DWIDTH  operand/result width (must match alu_128bit)
//   NREQ    number of requesters (2..16)
//   IDW     requester id width, derived from NREQ
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   per-requester handshake; req_ready is a one-hot grant,
//                         driven combinationally and only in IDLE
//   req_op1/req_op2       packed operands, requester k at [k*DWIDTH +: DWIDTH]
//   req_opsel             packed opsel, requester k at [k*3 +: 3]
//   req_mode              per-requester mode (0 arith, 1 logic)
//   alu_op1..alu_mode     registered drive into alu_128bit
//   alu_result/alu_flags  combinational return from alu_128bit ({c,z,o,s})
//   rsp_valid/rsp_ready   response handshake
//   rsp_id/rsp_result/rsp_flags/rsp_err
//                         served requester, captured result and flags, and an
//                         error bit for undefined {mode,opsel} codes
// -----------------------------------------------------------------------------
module alu_128_req_arbiter #(
  parameter  int DWIDTH = 128,
  parameter  int NREQ   = 4,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DWIDTH-1:0] req_op1,
  input  logic [NREQ*DWIDTH-1:0] req_op2,
  input  logic [NREQ*3-1:0]      req_opsel,
  input  logic [NREQ-1:0]        req_mode,
  output logic [DWIDTH-1:0]      alu_op1,
  output logic [DWIDTH-1:0]      alu_op2,
  output logic [2:0]             alu_opsel,
  output logic                   alu_mode,
  input  logic [DWIDTH-1:0]      alu_result,
  input  logic [3:0]             alu_flags,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [DWIDTH-1:0]      rsp_result,
  output logic [3:0]             rsp_flags,
  output logic                   rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state;
  logic [IDW-1:0] ptr;        // highest-priority requester for the next grant
  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [IDW:0]   cand;       // one extra bit so ptr+i cannot overflow before wrap
  logic           code_undef;
  logic [IDW-1:0] next_ptr;

  // Round-robin search: first valid requester at or after ptr, wrapping.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!grant_found && req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  // Grant is only offered while idle; the accepting edge is the IDLE->EXEC edge.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Codes 7, C, E, F have no ALU meaning; their result is forced to zero.
  always_comb begin
    unique case ({alu_mode, alu_opsel})
      4'h7, 4'hC, 4'hE, 4'hF: code_undef = 1'b1;
      default:                code_undef = 1'b0;
    endcase
  end

  // rsp_id holds the served requester, so the pointer advances past it.
  assign next_ptr = (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      alu_opsel  <= '0;
      alu_mode   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_found) begin
            alu_op1   <= req_op1[grant_idx*DWIDTH +: DWIDTH];
            alu_op2   <= req_op2[grant_idx*DWIDTH +: DWIDTH];
            alu_opsel <= req_opsel[grant_idx*3 +: 3];
            alu_mode  <= req_mode[grant_idx];
            rsp_id    <= grant_idx;
            state     <= EXEC;
          end
        end
        EXEC: begin
          if (code_undef) begin
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b1;
          end else begin
            rsp_result <= alu_result;
            rsp_flags  <= alu_flags;
            rsp_err    <= 1'b0;
          end
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ptr       <= next_ptr;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_128_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_128_req_arbiter
//
// Self-checking bench for alu_128_req_arbiter (DWIDTH=128, NREQ=4). A
// behavioural alu_128bit stand-in closes the ALU loop. The bench runs a table
// of single-requester vectors with hand-computed results, hand-written
// multi-cycle sequences (fairness, back-pressure, mid-flight reset and pointer
// wrap), and a randomized run against a round-robin reference model.
// -----------------------------------------------------------------------------
module tb_alu_128_req_arbiter;

  localparam int D = 128;
  localparam int N = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*D-1:0] req_op1;
  logic [N*D-1:0] req_op2;
  logic [N*3-1:0] req_opsel;
  logic [N-1:0]   req_mode;
  logic [D-1:0]   alu_op1;
  logic [D-1:0]   alu_op2;
  logic [2:0]     alu_opsel;
  logic           alu_mode;
  logic [D-1:0]   alu_result;
  logic [3:0]     alu_flags;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [D-1:0]   rsp_result;
  logic [3:0]     rsp_flags;
  logic           rsp_err;

  int checks   = 0;
  int failures = 0;

  alu_128_req_arbiter #(.DWIDTH(D), .NREQ(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .req_opsel  (req_opsel),
    .req_mode   (req_mode),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_opsel  (alu_opsel),
    .alu_mode   (alu_mode),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .rsp_err    (rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural ALU: returns {c,z,o,s, result}. Undefined codes return junk
  // so the arbiter's zeroing of them is observable.
  function automatic logic [D+3:0] ref_alu(input logic m, input logic [2:0] s,
                                           input logic [D-1:0] a, input logic [D-1:0] b);
    logic [D:0]   wide;
    logic [D-1:0] r;
    logic         c;
    logic         o;
    c = 1'b0;
    o = 1'b0;
    r = '0;
    wide = '0;
    case ({m, s})
      4'h0: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[D-1:0];
        c = wide[D];
        o = (a[D-1] == b[D-1]) && (r[D-1] != a[D-1]);
      end
      4'h1: begin
        r = a - b;
        c = (a >= b);
        o = (a[D-1] != b[D-1]) && (r[D-1] != a[D-1]);
      end
      4'h2: r = a + 1'b1;
      4'h3: r = a - 1'b1;
      4'h4: r = a << 1;
      4'h5: r = a >> 1;
      4'h6: r = '0 - a;
      4'h8: r = a & b;
      4'h9: r = a | b;
      4'hA: r = a ^ b;
      4'hB: r = ~a;
      4'hD: r = ~(a & b);
      default: return {4'hF, {(D/16){16'hDEAD}}};
    endcase
    return {c, (r == '0), o, r[D-1], r};
  endfunction

  always_comb {alu_flags, alu_result} = ref_alu(alu_mode, alu_opsel, alu_op1, alu_op2);

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic m, input logic [2:0] s,
                         input logic [D-1:0] a, input logic [D-1:0] b);
    req_op1[k*D +: D] = a;
    req_op2[k*D +: D] = b;
    req_opsel[k*3 +: 3] = s;
    req_mode[k] = m;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One isolated transaction from IDLE with rsp_ready held high.
  task automatic do_txn(input int k, input logic m, input logic [2:0] s,
                        input logic [D-1:0] a, input logic [D-1:0] b,
                        input logic [D-1:0] eres, input logic [3:0] eflg, input logic eerr,
                        input string name);
    set_req(k, m, s, a, b);
    req_valid = 4'b1 << k;
    #1;
    check({name, ".grant"}, req_ready, 4'b1 << k);
    tick();
    req_valid = '0;
    check({name, ".exec"}, {rsp_valid, req_ready}, 5'b0);
    tick();
    check({name, ".rsp"}, {rsp_valid, rsp_id, rsp_err, rsp_flags, rsp_result},
          {1'b1, 2'(k), eerr, eflg, eres});
    tick();
    check({name, ".done"}, rsp_valid, 1'b0);
  endtask

  typedef struct {
    int          k;
    logic        m;
    logic [2:0]  s;
    logic [D-1:0] a;
    logic [D-1:0] b;
    logic [D-1:0] res;
    logic [3:0]  flg;
    logic        err;
  } vec_t;

  vec_t vecs[11];

  // Random-run model state.
  int           mptr;
  int           mph;
  int           mg;
  logic [134:0] mexp;
  logic [3:0]   mask;
  logic [D+3:0] fr;

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_op1 = '0;
    req_op2 = '0;
    req_opsel = '0;
    req_mode = '0;
    rsp_ready = 1'b1;

    vecs[0]  = '{0, 1'b0, 3'd0, 128'd5, 128'd3, 128'd8, 4'b0000, 1'b0};
    vecs[1]  = '{1, 1'b0, 3'd1, 128'd10, 128'd3, 128'd7, 4'b1000, 1'b0};
    vecs[2]  = '{3, 1'b0, 3'd0, {128{1'b1}}, 128'd1, 128'd0, 4'b1100, 1'b0};
    vecs[3]  = '{2, 1'b0, 3'd0, {1'b0, {127{1'b1}}}, 128'd1, {1'b1, 127'd0}, 4'b0011, 1'b0};
    vecs[4]  = '{0, 1'b1, 3'd0, 128'hF0, 128'h3C, 128'h30, 4'b0000, 1'b0};
    vecs[5]  = '{1, 1'b1, 3'd1, 128'hF0, 128'h3C, 128'hFC, 4'b0000, 1'b0};
    vecs[6]  = '{3, 1'b1, 3'd2, 128'hF0, 128'h3C, 128'hCC, 4'b0000, 1'b0};
    vecs[7]  = '{2, 1'b1, 3'd7, 128'h12, 128'h34, 128'd0, 4'b0000, 1'b1};
    vecs[8]  = '{1, 1'b0, 3'd7, 128'h12, 128'h34, 128'd0, 4'b0000, 1'b1};
    vecs[9]  = '{0, 1'b1, 3'd4, 128'h12, 128'h34, 128'd0, 4'b0000, 1'b1};
    vecs[10] = '{3, 1'b1, 3'd6, 128'h12, 128'h34, 128'd0, 4'b0000, 1'b1};

    // Reset state.
    do_reset();
    check("reset.rsp", {rsp_valid, rsp_id, rsp_err, rsp_flags, rsp_result}, '0);
    check("reset.alu", {alu_mode, alu_opsel, alu_op2, alu_op1}, '0);
    check("reset.ready", req_ready, 4'b0);

    // Table of isolated transactions.
    for (int i = 0; i < 11; i++) begin
      do_txn(vecs[i].k, vecs[i].m, vecs[i].s, vecs[i].a, vecs[i].b,
             vecs[i].res, vecs[i].flg, vecs[i].err, $sformatf("vec%0d", i));
    end

    // Fairness: all requesters valid from reset, one grant every 3 cycles.
    do_reset();
    for (int k = 0; k < N; k++) set_req(k, 1'b0, 3'd0, 128'(k), 128'd100);
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    #1;
    for (int c = 0; c < 15; c++) begin
      check($sformatf("rr.ready%0d", c), req_ready,
            (c % 3 == 0) ? (4'b1 << ((c / 3) % N)) : 4'b0);
      if (c % 3 == 2) begin
        check($sformatf("rr.rsp%0d", c), {rsp_valid, rsp_id, rsp_result},
              {1'b1, 2'((c / 3) % N), 128'(100 + (c / 3) % N)});
      end
      tick();
    end
    req_valid = '0;
    tick();

    // Back-pressure: response held stable while rsp_ready is low.
    do_reset();
    set_req(0, 1'b1, 3'd0, 128'hF0, 128'h3C);
    set_req(1, 1'b0, 3'd0, 128'd1, 128'd1);
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    #1;
    check("bp.grant", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0010;
    tick();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp.hold%0d", c), {rsp_valid, req_ready, rsp_id, rsp_result},
            {1'b1, 4'b0, 2'd0, 128'h30});
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    check("bp.release", rsp_valid, 1'b0);

    // Reset in EXEC with req1 still valid: ptr must return to 0.
    do_txn(1, 1'b0, 3'd0, 128'd1, 128'd1, 128'd2, 4'b0000, 1'b0, "pre_rst");
    set_req(1, 1'b1, 3'd2, 128'hAA, 128'h0F);
    set_req(3, 1'b0, 3'd0, 128'd7, 128'd7);
    req_valid = 4'b0010;
    #1;
    check("mrst.grant", req_ready, 4'b0010);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst.state", {rsp_valid, alu_mode, alu_opsel, alu_op2, alu_op1}, '0);
    req_valid = 4'b1010;
    #1;
    check("mrst.regrant", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    tick();
    check("mrst.rsp", {rsp_valid, rsp_id, rsp_err, rsp_result}, {1'b1, 2'd1, 1'b0, 128'hA5});
    tick();

    // Pointer at 3 after serving req2: req3 wins over req0, then req0.
    do_txn(2, 1'b0, 3'd0, 128'd2, 128'd2, 128'd4, 4'b0000, 1'b0, "pre_wrap");
    set_req(0, 1'b0, 3'd0, 128'd20, 128'd1);
    set_req(3, 1'b0, 3'd0, 128'd30, 128'd1);
    req_valid = 4'b1001;
    #1;
    check("wrap.first", req_ready, 4'b1000);
    tick();
    req_valid = 4'b0001;
    tick();
    check("wrap.rsp3", {rsp_valid, rsp_id, rsp_result}, {1'b1, 2'd3, 128'd31});
    tick();
    check("wrap.second", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    tick();
    check("wrap.rsp0", {rsp_valid, rsp_id, rsp_result}, {1'b1, 2'd0, 128'd21});
    tick();

    // Randomized run against a round-robin reference model.
    do_reset();
    mptr = 0;
    mph = 0;
    mg = 0;
    mexp = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) mask = '0;
      for (int k = 0; k < N; k++) begin
        set_req(k, 1'($urandom()), 3'($urandom()),
                ($urandom_range(0, 7) == 0) ? {D{1'b1}} : {$urandom(), $urandom(), $urandom(), $urandom()},
                ($urandom_range(0, 7) == 0) ? 128'd1 : {$urandom(), $urandom(), $urandom(), $urandom()});
      end
      req_valid = mask;
      rsp_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (mph == 0) begin
        mg = -1;
        for (int i = 0; i < N; i++) begin
          if (mg < 0 && mask[(mptr + i) % N]) mg = (mptr + i) % N;
        end
        if (mg >= 0) begin
          check("rand.grant", req_ready, 4'b1 << mg);
          if ({req_mode[mg], req_opsel[mg*3 +: 3]} inside {4'h7, 4'hC, 4'hE, 4'hF}) begin
            mexp = {2'(mg), 1'b1, 4'b0, 128'd0};
          end else begin
            fr = ref_alu(req_mode[mg], req_opsel[mg*3 +: 3], req_op1[mg*D +: D], req_op2[mg*D +: D]);
            mexp = {2'(mg), 1'b0, fr};
          end
          mph = 1;
        end else begin
          check("rand.idle", {rsp_valid, req_ready}, 5'b0);
        end
      end else if (mph == 1) begin
        check("rand.exec", {rsp_valid, req_ready}, 5'b0);
        mph = 2;
      end else begin
        check("rand.rsp", {rsp_valid, req_ready, rsp_id, rsp_err, rsp_flags, rsp_result},
              {1'b1, 4'b0, mexp});
        if (rsp_ready) begin
          mptr = (mg + 1) % N;
          mph = 0;
        end
      end
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
